// File: rtl/ttl_74166.sv
`timescale 1ns/1ns
// ttl_74166: WIDTH-bit parallel-in/serial-out shift register (74166 style), serial output is the last stage.
// Latency: a load shows D[WIDTH-1] on Q one Clk rise later; D[k] follows after (WIDTH-1-k) further shifts, plus output delay.
// No backpressure: CE_bar high inhibits the clock (hold), Clear_bar low clears asynchronously and masks all edges.
module ttl_74166 #(
   parameter int WIDTH      = 8,
   parameter int DELAY_RISE = 0,
   parameter int DELAY_FALL = 0
) (
   input  logic             Clk,
   input  logic             Clear_bar,
   input  logic             PE_bar,
   input  logic             CE_bar,
   input  logic             DS,
   input  logic [WIDTH-1:0] D,
   output logic             Q
);

   logic [WIDTH-1:0] s;
   logic             last_stage;
   logic             q_rise;
   logic             q_fall;

   // Register: async clear wins; otherwise CE_bar inhibits, then PE_bar picks load over shift.
   // Unknown control values poison the register rather than silently choosing a branch.
   always_ff @(posedge Clk or negedge Clear_bar) begin
      if (!Clear_bar) begin
         s <= '0;
      end else begin
         case (CE_bar)
            1'b1: s <= s;
            1'b0: begin
               case (PE_bar)
                  1'b0:    s <= D;
                  1'b1:    s <= {s[WIDTH-2:0], DS};
                  default: s <= 'x;
               endcase
            end
            default: s <= 'x;
         endcase
      end
   end

   assign last_stage = s[WIDTH-1];

   // Separate rise and fall delay paths; the current level of the last stage selects
   // which path drives Q, so a 0->1 edge appears after DELAY_RISE and a 1->0 edge after DELAY_FALL.
   assign #(DELAY_RISE) q_rise = last_stage;
   assign #(DELAY_FALL) q_fall = last_stage;
   assign Q = last_stage ? q_rise : q_fall;

endmodule
